// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile -- write-back stage plus 32 x 32-bit register file.
//
// Selects the write-back value from the MEM/WB register (load data or ALU
// result), commits it to the register file when RegWrite is set and the
// destination is not x0, and counts committed writes.
//
// Configuration macro:
//   WB_BYPASS_EN  when defined, a read of the register being written in the
//                 current cycle returns the value being written (write-through).
//                 When undefined, the read returns the old stored value and
//                 the new value is visible from the next cycle.
//
// Parameters:
//   COUNT_W         width of the commit counter (wraps modulo 2^COUNT_W)
//
// Ports:
//   clk             pipeline clock, rising edge
//   rst_n           asynchronous active-low reset (clears registers, counter)
//   WB[1:0]         bit1 RegWrite, bit0 MemtoReg
//   read_data       load data from MEM/WB
//   ALU_result      ALU result from MEM/WB
//   RegDst_address  destination register index
//   read_reg1/2     decode-stage source indices
//   read_data1/2    combinational register read values
//   wb_data         selected write-back value (for forwarding)
//   wb_we           qualified write enable (RegWrite and destination != 0)
//   wb_count        committed register writes since reset
//
// Handshake: none. Every cycle with wb_we=1 commits exactly one write; the
// block never stalls and applies no backpressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_regfile #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         WB,
  input  logic [31:0]        read_data,
  input  logic [31:0]        ALU_result,
  input  logic [4:0]         RegDst_address,
  input  logic [4:0]         read_reg1,
  input  logic [4:0]         read_reg2,
  output logic [31:0]        read_data1,
  output logic [31:0]        read_data2,
  output logic [31:0]        wb_data,
  output logic               wb_we,
  output logic [COUNT_W-1:0] wb_count
);

  logic [31:0]        regs_q [32];
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  assign wb_data = WB[0] ? read_data : ALU_result;
  // A write to x0 is not a commit: no storage change and no count.
  assign wb_we   = WB[1] && (RegDst_address != 5'd0);

  // Entry 0 is cleared by reset and never written; reads of index 0 are also
  // forced to zero below so x0 is hard-wired regardless of storage contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wb_we && (RegDst_address == 5'(i))) begin
          regs_q[i] <= wb_data;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (wb_we) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign wb_count = count_q;

  // wb_we already excludes index 0, so the bypass can never make x0 nonzero.
  always_comb begin
    read_data1 = (read_reg1 == 5'd0) ? 32'd0 : regs_q[read_reg1];
    read_data2 = (read_reg2 == 5'd0) ? 32'd0 : regs_q[read_reg2];
`ifdef WB_BYPASS_EN
    if (wb_we && (read_reg1 == RegDst_address)) begin
      read_data1 = wb_data;
    end
    if (wb_we && (read_reg2 == RegDst_address)) begin
      read_data2 = wb_data;
    end
`else
`endif
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one parameter: COUNT_W, default 32, width of the write-back commit counter.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 WB  input  2  write-back control from the MEM/WB register: bit1 RegWrite, bit0 MemtoReg.
REQ-005 read_data  input  32  memory load data from MEM/WB.
REQ-006 ALU_result  input  32  ALU result from MEM/WB.
REQ-007 RegDst_address  input  5  destination register index from MEM/WB.
REQ-008 read_reg1  input  5  decode-stage source register index, port 1.
REQ-009 read_reg2  input  5  decode-stage source register index, port 2.
REQ-010 read_data1  output  32  register value for read_reg1.
REQ-011 read_data2  output  32  register value for read_reg2.
REQ-012 wb_data  output  32  selected write-back value, for the forwarding unit.
REQ-013 wb_we  output  1  qualified write enable: WB[1] and RegDst_address != 0.
REQ-014 wb_count  output  COUNT_W  number of committed register writes since reset.

Function
REQ-015 wb_data SHALL be read_data when WB[0]=1, else ALU_result; combinational, zero latency.
REQ-016 Storage SHALL be 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-017 On a rising clk edge with wb_we=1, register[RegDst_address] SHALL take wb_data; visible on read ports from the following cycle.
REQ-018 WB[1]=1 with RegDst_address=0 SHALL NOT write any register and SHALL NOT increment wb_count.
REQ-019 WB[1]=0 SHALL NOT write regardless of WB[0], read_data, ALU_result or RegDst_address.
REQ-020 read_data1/read_data2 SHALL be combinational functions of read_reg1/read_reg2 and stored state (plus the bypass of REQ-027 when enabled).
REQ-021 Both read ports SHALL be independent; read_reg1 = read_reg2 SHALL return identical values.
REQ-022 wb_count SHALL increment by 1 on every rising edge with wb_we=1; modulo 2^COUNT_W, wrapping from all-ones to 0 without stalling.
REQ-023 The block SHALL perform at most one register write per cycle; no internal stalls, no backpressure.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) clear all 32 registers and wb_count to 0, regardless of clk.
REQ-025 A write coinciding with rst_n assertion SHALL be discarded; the register reads 0.
REQ-026 After rst_n deasserts, the first write SHALL occur on the first rising edge with wb_we=1; read ports SHALL return 0 for all indices until then.

Configuration
REQ-027 With macro WB_BYPASS_EN defined: when wb_we=1 and read_regN = RegDst_address, read_dataN SHALL return wb_data in the same cycle (write-through bypass); read_reg=0 SHALL still return 0.
REQ-028 Without WB_BYPASS_EN: read ports SHALL return the pre-write stored value during the write cycle; the new value appears the next cycle.

Verification
REQ-029 Reset then read all 32 indices on both ports -> every read returns 0x00000000, wb_count=0.
REQ-030 WB=2'b10, ALU_result=0xDEADBEEF, RegDst_address=5, one edge, read_reg1=5 -> read_data1=0xDEADBEEF, wb_count=1; then WB=2'b11, read_data=0x12345678, RegDst_address=5 -> reg5=0x12345678, wb_count=2.
REQ-031 WB=2'b10, RegDst_address=0, ALU_result=0xFFFFFFFF -> read_data1 for index 0 stays 0, wb_count unchanged, wb_we=0.
REQ-032 reg7=0x1; in-cycle write WB=2'b10, RegDst_address=7, ALU_result=0x2, read_reg2=7 -> read_data2=0x2 with WB_BYPASS_EN, 0x1 without; both read 0x2 after the edge.
REQ-033 COUNT_W=4, 17 qualified writes -> wb_count sequence 1..15,0,1; writes to all registers intact.
REQ-034 rst_n pulsed low mid-cycle after writing regs 1..31 with nonzero data -> all reads return 0 immediately, before any clk edge; wb_count=0.
